ddr_responder: RTL

//  Memory-side end of the core's DDR request interface; the core's channel arbiter is the initiator.

---
 rtl/ddr_responder_if.sv | 26 ++
 rtl/ddr_responder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ddr_responder_if.sv
// Request/response bundle between the channel arbiter (master) and the DDR responder (slave).
// One request in flight; ddr_ready gates acceptance, ddr_operation_done pulses on completion.
interface ddr_responder_if;
    logic         ddr_chip_enable;
    logic [18:0]  ddr_index;
    logic         ddr_write_enable;
    logic         ddr_burst_mode;
    logic [63:0]  ddr_opstore_write_mask;
    logic [63:0]  ddr_opstore_write_data;
    logic [63:0]  ddr_opload_read_data;
    logic [511:0] ddr_pc_read_inst;
    logic         ddr_operation_done;
    logic         ddr_ready;

    modport master (
        output ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
               ddr_opstore_write_mask, ddr_opstore_write_data,
        input  ddr_opload_read_data, ddr_pc_read_inst, ddr_operation_done, ddr_ready
    );

    modport slave (
        input  ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
               ddr_opstore_write_mask, ddr_opstore_write_data,
        output ddr_opload_read_data, ddr_pc_read_inst, ddr_operation_done, ddr_ready
    );
endinterface

// File: rtl/ddr_responder.sv
// Single-outstanding DDR model / on-chip RAM: masked write, single read, 8-beat wrapping burst read.
// Latency LATENCY+1 cycles (single) or LATENCY+9 (burst) to done; requests ignored while ddr_ready=0.
module ddr_responder #(
    parameter int    MEM_AW    = 16,
    parameter int    LATENCY   = 4,
    parameter string INIT_FILE = ""
) (
    input  logic            clock,
    input  logic            reset_n,
    ddr_responder_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_e;

    localparam logic [7:0] LAT_INIT = 8'(LATENCY - 1);

    logic [63:0] mem [0:(2**MEM_AW)-1];

    state_e              state_q, state_d;
    logic [7:0]          lat_q, lat_d;
    logic [2:0]          beat_q, beat_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic                burst_q, burst_d;
    logic [63:0]         mask_q, mask_d;
    logic [63:0]         data_q, data_d;
    logic [63:0]         rdata_q, rdata_d;
    logic [511:0]        inst_q, inst_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;

    logic [MEM_AW-1:0]   mem_addr;
    logic                mem_we;
    logic [63:0]         rd_word;
    logic [63:0]         wr_word;

    // Upper index bits alias onto the array.
    logic unused_idx;
    assign unused_idx = &{1'b0, bus.ddr_index};

    assign rd_word = mem[mem_addr];
    assign wr_word = (rd_word & ~mask_q) | (data_q & mask_q);

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        beat_d   = beat_q;
        addr_d   = addr_q;
        we_d     = we_q;
        burst_d  = burst_q;
        mask_d   = mask_q;
        data_d   = data_q;
        rdata_d  = rdata_q;
        inst_d   = inst_q;
        mem_addr = addr_q;
        mem_we   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.ddr_chip_enable) begin
                    addr_d  = bus.ddr_index[MEM_AW-1:0];
                    we_d    = bus.ddr_write_enable;
                    burst_d = bus.ddr_burst_mode;
                    mask_d  = bus.ddr_opstore_write_mask;
                    data_d  = bus.ddr_opstore_write_data;
                    lat_d   = LAT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_q == 8'd0) begin
                    if (burst_q) begin
                        beat_d  = 3'd0;
                        state_d = S_BURST;
                    end else if (we_q) begin
                        mem_we  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        rdata_d = rd_word;
                        state_d = S_DONE;
                    end
                end else begin
                    lat_d = lat_q - 8'd1;
                end
            end
            S_BURST: begin
                // Address arithmetic at MEM_AW width wraps at the array top.
                mem_addr = addr_q + MEM_AW'(beat_q);
                inst_d[{beat_q, 6'b0} +: 64] = rd_word;
                if (beat_q == 3'd7) begin
                    state_d = S_DONE;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d  = (state_d == S_DONE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            lat_q   <= 8'd0;
            beat_q  <= 3'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            burst_q <= 1'b0;
            mask_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            inst_q  <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            burst_q <= burst_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            inst_q  <= inst_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    // Array is never reset; a reset arriving on the commit edge drops the write.
    always_ff @(posedge clock) begin
        if (mem_we && reset_n) begin
            mem[mem_addr] <= wr_word;
        end
    end

    assign bus.ddr_opload_read_data = rdata_q;
    assign bus.ddr_pc_read_inst     = inst_q;
    assign bus.ddr_operation_done   = done_q;
    assign bus.ddr_ready            = ready_q;
endmodule
